dram_uart_transmitter: RTL and testbench

- Streams the processed (downsampled) image out of data memory to the PC over a UART TX line.
- It is the transmit-direction counterpart of the image receiver. It is started by begin_transmit from the main controller and reports completion on end_transmit, which drives the controller out of the transmit state.
- Shares the data memory port with the processor through the top-level address mux. The block owns the port only while busy.

---
 rtl/dram_uart_transmitter.sv | 148 ++++++++++++++
 tb/tb_dram_uart_transmitter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dram_uart_transmitter.sv
// Streams IMG_BYTES bytes from data memory (starting at BASE_ADDR) out of an 8N1 UART TX line.
// The memory port is driven only while a run is in progress; the top-level mux keys off tx_busy.
module dram_uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int          ADDR_WIDTH   = 20,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned IMG_BYTES    = 16384,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  begin_transmit,
    input  logic [7:0]            dm_q,
    output logic [ADDR_WIDTH-1:0] dm_addr,
    output logic                  dm_r,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  end_transmit,
    output logic [ADDR_WIDTH-1:0] tx_byte_count
);

    localparam int unsigned CNT_MAX = (CLKS_PER_BIT > READ_LATENCY) ? CLKS_PER_BIT : READ_LATENCY + 1;
    localparam int          CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FETCH_END = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] CAPTURE   = CW'(READ_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] IMG_LAST = ADDR_WIDTH'(IMG_BYTES);

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, DONE} state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [2:0]              bit_q;
    logic [7:0]              shift_q;
    logic                    tx_q;
    logic                    busy_q;
    logic                    end_q;
    logic                    rd_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   count_q;
    logic [ADDR_WIDTH-1:0]   count_d;
    logic                    bit_end;

    assign bit_end = (cnt_q == BIT_END);
    assign count_d = count_q + ADDR_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (begin_transmit && !end_q) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                        addr_q  <= BASE_ADDR;
                        count_q <= '0;
                        rd_q    <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                // dm_r is held READ_LATENCY cycles, then one extra cycle samples dm_q.
                FETCH: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == FETCH_END) begin
                        rd_q <= 1'b0;
                    end
                    if (cnt_q == CAPTURE) begin
                        shift_q <= dm_q;
                        tx_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        count_q <= count_d;
                        if (count_d == IMG_LAST) begin
                            busy_q  <= 1'b0;
                            end_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            addr_q  <= addr_q + ADDR_WIDTH'(1);
                            rd_q    <= 1'b1;
                            state_q <= FETCH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                // Hold completion until the request level drops, so a held request cannot re-trigger.
                DONE: begin
                    tx_q <= 1'b1;
                    if (!begin_transmit) begin
                        end_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dm_addr       = addr_q;
    assign dm_r          = rd_q;
    assign tx            = tx_q;
    assign tx_busy       = busy_q;
    assign end_transmit  = end_q;
    assign tx_byte_count = count_q;

endmodule

// File: tb/tb_dram_uart_transmitter.sv
// Directed bench: three transmitter instances (single byte, 3-byte stream, address wrap) sharing one
// memory image behind a two-stage read pipeline; frames are sampled every cycle and checked bit-exact.
module tb_dram_uart_transmitter;

    localparam int CPB = 4;
    localparam int RL  = 2;
    localparam int AW  = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst  [3];
    logic          beg  [3];
    logic [7:0]    q    [3];
    logic [7:0]    s1   [3];
    logic [AW-1:0] addr [3];
    logic [AW-1:0] cnt  [3];
    logic          rd   [3];
    logic          tx   [3];
    logic          busy [3];
    logic          endt [3];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
        case (a)
            20'h00000: mem_rd = 8'hA5;
            20'h00100: mem_rd = 8'h00;
            20'h00101: mem_rd = 8'hFF;
            20'h00102: mem_rd = 8'h3C;
            20'hFFFFF: mem_rd = 8'h5A;
            default:   mem_rd = 8'hEE;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            s1[i] <= mem_rd(addr[i]);
            q[i]  <= s1[i];
        end
    end

    dram_uart_transmitter #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .BASE_ADDR(20'h00000),
                            .IMG_BYTES(1), .READ_LATENCY(RL)) u_one (
        .clock(clk), .reset(rst[0]), .begin_transmit(beg[0]), .dm_q(q[0]), .dm_addr(addr[0]),
        .dm_r(rd[0]), .tx(tx[0]), .tx_busy(busy[0]), .end_transmit(endt[0]), .tx_byte_count(cnt[0]));

    dram_uart_transmitter #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .BASE_ADDR(20'h00100),
                            .IMG_BYTES(3), .READ_LATENCY(RL)) u_multi (
        .clock(clk), .reset(rst[1]), .begin_transmit(beg[1]), .dm_q(q[1]), .dm_addr(addr[1]),
        .dm_r(rd[1]), .tx(tx[1]), .tx_busy(busy[1]), .end_transmit(endt[1]), .tx_byte_count(cnt[1]));

    dram_uart_transmitter #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .BASE_ADDR(20'hFFFFF),
                            .IMG_BYTES(2), .READ_LATENCY(RL)) u_wrap (
        .clock(clk), .reset(rst[2]), .begin_transmit(beg[2]), .dm_q(q[2]), .dm_addr(addr[2]),
        .dm_r(rd[2]), .tx(tx[2]), .tx_busy(busy[2]), .end_transmit(endt[2]), .tx_byte_count(cnt[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Returns on the negedge of the first start-bit cycle; gap counts idle-high samples before it.
    task automatic wait_start(input int i, output int gap, output logic [AW-1:0] ra);
        gap = 0;
        ra  = 'x;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rd[i] === 1'b1) ra = addr[i];
            if (tx[i] === 1'b0) return;
            gap++;
        end
        chk("start_timeout", 32'(tx[i]), 32'h0);
    endtask

    // Samples 10 bits x CPB cycles starting at the current negedge; fr[0] is the start bit.
    task automatic rx_rest(input int i, output logic [9:0] fr, output logic shape_ok);
        shape_ok = 1'b1;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (c == 0) fr[b] = tx[i];
                else if (tx[i] !== fr[b]) shape_ok = 1'b0;
            end
        end
    endtask

    int            gap;
    logic [AW-1:0] ra;
    logic [9:0]    fr;
    logic          ok;
    int            hold_bad;
    logic [7:0]    exp_b [3];

    initial begin
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            beg[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("rst_tx",   32'(tx[0]),   32'h1);
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_end",  32'(endt[0]), 32'h0);
        chk("rst_dm_r", 32'(rd[0]),   32'h0);
        chk("rst_addr", 32'(addr[0]), 32'h0);
        chk("rst_cnt",  32'(cnt[0]),  32'h0);

        // Single byte A5, begin_transmit pulsed for one cycle.
        rst[0] = 1'b0;
        @(negedge clk);
        chk("one_busy", 32'(busy[0]), 32'h1);
        chk("one_dm_r", 32'(rd[0]),   32'h1);
        chk("one_addr", 32'(addr[0]), 32'h0);
        beg[0] = 1'b0;
        wait_start(0, gap, ra);
        rx_rest(0, fr, ok);
        chk("one_frame", 32'(fr), 32'({1'b1, 8'hA5, 1'b0}));
        chk("one_shape", 32'(ok), 32'h1);
        @(negedge clk);
        chk("one_end",  32'(endt[0]), 32'h1);
        chk("one_cnt",  32'(cnt[0]),  32'h1);
        chk("one_idle", 32'(busy[0]), 32'h0);
        chk("one_txhi", 32'(tx[0]),   32'h1);
        @(negedge clk);
        chk("one_end_drop", 32'(endt[0]), 32'h0);

        // Three-byte stream from 0x100 with begin_transmit held.
        rst[1] = 1'b0;
        for (int f = 0; f < 3; f++) begin
            wait_start(1, gap, ra);
            chk("multi_addr", 32'(ra), 32'(20'h100 + f));
            chk("multi_gap", gap, 32'(RL + 1));
            rx_rest(1, fr, ok);
            chk("multi_frame", 32'(fr), 32'({1'b1, exp_b[f], 1'b0}));
            chk("multi_shape", 32'(ok), 32'h1);
        end
        @(negedge clk);
        chk("multi_end", 32'(endt[1]), 32'h1);
        chk("multi_cnt", 32'(cnt[1]),  32'h3);

        hold_bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (endt[1] !== 1'b1 || rd[1] !== 1'b0 || tx[1] !== 1'b1) hold_bad++;
        end
        chk("hold_stable", hold_bad, 0);
        beg[1] = 1'b0;
        @(negedge clk);
        chk("hold_end_drop", 32'(endt[1]), 32'h0);

        beg[1] = 1'b1;
        wait_start(1, gap, ra);
        chk("rerun_addr", 32'(ra), 32'h100);
        chk("rerun_gap", gap, 32'(RL + 1));
        rx_rest(1, fr, ok);
        chk("rerun_frame", 32'(fr), 32'({1'b1, 8'h00, 1'b0}));
        wait_start(1, gap, ra);
        chk("rerun_addr2", 32'(ra), 32'h101);
        repeat (CPB + 3 * CPB + 1) @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        chk("midrst_tx",   32'(tx[1]),   32'h1);
        chk("midrst_busy", 32'(busy[1]), 32'h0);
        chk("midrst_end",  32'(endt[1]), 32'h0);
        chk("midrst_dm_r", 32'(rd[1]),   32'h0);
        chk("midrst_addr", 32'(addr[1]), 32'h100);
        chk("midrst_cnt",  32'(cnt[1]),  32'h0);
        rst[1] = 1'b0;
        wait_start(1, gap, ra);
        chk("restart_addr", 32'(ra), 32'h100);
        chk("restart_cnt", 32'(cnt[1]), 32'h0);
        rx_rest(1, fr, ok);
        chk("restart_frame", 32'(fr), 32'({1'b1, 8'h00, 1'b0}));
        rst[1] = 1'b1;

        // Address wrap: 0xFFFFF then 0x00000.
        rst[2] = 1'b0;
        wait_start(2, gap, ra);
        chk("wrap_addr0", 32'(ra), 32'hFFFFF);
        rx_rest(2, fr, ok);
        chk("wrap_frame0", 32'(fr), 32'({1'b1, 8'h5A, 1'b0}));
        wait_start(2, gap, ra);
        chk("wrap_addr1", 32'(ra), 32'h00000);
        rx_rest(2, fr, ok);
        chk("wrap_frame1", 32'(fr), 32'({1'b1, 8'hA5, 1'b0}));
        chk("wrap_shape", 32'(ok), 32'h1);
        @(negedge clk);
        chk("wrap_end", 32'(endt[2]), 32'h1);
        chk("wrap_cnt", 32'(cnt[2]),  32'h2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
